// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage register pipeline with a valid bit riding alongside
// each data stage.
//
// Parameters
//    WIDTH  data bits per stage (>=1)
//    DEPTH  number of register stages (>=1)
//    INIT   value loaded into every data stage on reset and on clear
//
// Ports
//    CK     clock, rising edge
//    RST_N  asynchronous active-low reset
//    EN     advance enable (0 = every stage holds)
//    CLR    synchronous flush, takes priority over EN
//    VI     valid qualifier for D
//    D      input data, captured on every advance regardless of VI
//    Q      final-stage data (registered)
//    VO     final-stage valid (registered)
//    CNT    number of stages currently holding valid data
module dff_pipe #(
   parameter int unsigned      WIDTH = 8,
   parameter int unsigned      DEPTH = 4,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic                       CK,
   input  logic                       RST_N,
   input  logic                       EN,
   input  logic                       CLR,
   input  logic                       VI,
   input  logic [WIDTH-1:0]           D,
   output logic [WIDTH-1:0]           Q,
   output logic                       VO,
   output logic [$clog2(DEPTH+1)-1:0] CNT
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] s [DEPTH];
   logic [DEPTH-1:0] v;

   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            s[i] <= INIT;
         end
         v <= '0;
      end else if (CLR) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            s[i] <= INIT;
         end
         v <= '0;
      end else if (EN) begin
         s[0] <= D;
         v[0] <= VI;
         // Loops rather than slices so DEPTH=1 elaborates without a
         // reversed range.
         for (int unsigned i = 1; i < DEPTH; i++) begin
            s[i] <= s[i-1];
            v[i] <= v[i-1];
         end
      end
   end

   assign Q  = s[DEPTH-1];
   assign VO = v[DEPTH-1];

   always_comb begin
      CNT = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         CNT = CNT + CW'(v[i]);
      end
   end

endmodule

// File: tb/tb_dff_pipe.sv
module tb_dff_pipe;

   localparam int unsigned W  = 8;
   localparam int unsigned DP = 4;
   localparam int unsigned CW = $clog2(DP + 1);

   logic          CK = 1'b0;
   logic          RST_N = 1'b1;
   logic          EN = 1'b0, CLR = 1'b0, VI = 1'b0;
   logic [W-1:0]  D = '0;
   logic [W-1:0]  Q;
   logic          VO;
   logic [CW-1:0] CNT;

   logic          en1 = 1'b0, clr1 = 1'b0, vi1 = 1'b0;
   logic [W-1:0]  d1 = '0;
   logic [W-1:0]  q1;
   logic          vo1;
   logic          cnt1;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: a fixed-length queue, newest at the front
   logic [W-1:0] md[$];
   bit           mv[$];

   always #5 CK = ~CK;

   dff_pipe #(.WIDTH(W), .DEPTH(DP), .INIT(8'h00)) dut (
      .CK(CK), .RST_N(RST_N), .EN(EN), .CLR(CLR), .VI(VI), .D(D),
      .Q(Q), .VO(VO), .CNT(CNT));

   dff_pipe #(.WIDTH(W), .DEPTH(1), .INIT(8'h00)) dut1 (
      .CK(CK), .RST_N(RST_N), .EN(en1), .CLR(clr1), .VI(vi1), .D(d1),
      .Q(q1), .VO(vo1), .CNT(cnt1));

   function automatic void model_reset();
      md.delete();
      mv.delete();
      for (int i = 0; i < DP; i++) begin
         md.push_back(8'h00);
         mv.push_back(1'b0);
      end
   endfunction

   function automatic int model_cnt();
      int c = 0;
      foreach (mv[i]) c += int'(mv[i]);
      return c;
   endfunction

   // one rising edge: update model from the inputs the DUT sees, then settle
   task automatic tick();
      @(posedge CK);
      if (!RST_N) model_reset();
      else if (CLR) model_reset();
      else if (EN) begin
         md.push_front(D);
         mv.push_front(VI);
         void'(md.pop_back());
         void'(mv.pop_back());
      end
      #1;
   endtask

   task automatic do_reset();
      EN = 0; CLR = 0; VI = 0; D = '0;
      #2 RST_N = 1'b0;
      model_reset();
      #2 RST_N = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      #2 RST_N = 1'b0;
      model_reset();
      #1;
      if (Q !== 8'h00) begin n_bad++; $display("FAIL reset_q: got %h want 00", Q); end
      n_cmp++;
      if (VO !== 1'b0) begin n_bad++; $display("FAIL reset_vo: got %b want 0", VO); end
      n_cmp++;
      if (CNT !== 3'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", CNT); end
      n_cmp++;
      EN = 1; VI = 1; D = 8'hFF;
      tick();
      if (Q !== 8'h00 || CNT !== 3'd0) begin
         n_bad++; $display("FAIL reset_hold: got q=%h cnt=%0d want q=00 cnt=0", Q, CNT);
      end
      n_cmp++;
      #2 RST_N = 1'b1;
      EN = 0; VI = 0; D = '0;
      tick();
   endtask

   task automatic test_stream();
      logic [W-1:0] din  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      logic [W-1:0] eq   [5] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
      int           ecnt [5] = '{1, 2, 3, 4, 4};
      do_reset();
      EN = 1; VI = 1;
      for (int k = 0; k < 5; k++) begin
         D = din[k];
         tick();
         if (Q !== eq[k] || VO !== (k >= 3)) begin
            n_bad++;
            $display("FAIL stream_q edge %0d: got %h/%b want %h/%b", k + 1, Q, VO, eq[k], (k >= 3));
         end
         n_cmp++;
         if (int'(CNT) != ecnt[k]) begin
            n_bad++; $display("FAIL stream_cnt edge %0d: got %0d want %0d", k + 1, CNT, ecnt[k]);
         end
         n_cmp++;
      end
   endtask

   task automatic test_stall();
      bit           en_p [10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
      logic [W-1:0] din  [10] = '{8'h11, 8'h22, 8'hEE, 8'hEE, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      logic [W-1:0] eq   [10] = '{0, 0, 0, 0, 0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      int           ecnt [10] = '{1, 2, 2, 2, 3, 4, 4, 4, 4, 4};
      do_reset();
      VI = 1;
      for (int k = 0; k < 10; k++) begin
         EN = en_p[k];
         D  = din[k];
         tick();
         if (Q !== eq[k] || VO !== (eq[k] != 0)) begin
            n_bad++;
            $display("FAIL stall_q edge %0d: got %h/%b want %h/%b", k + 1, Q, VO, eq[k], (eq[k] != 0));
         end
         n_cmp++;
         if (int'(CNT) != ecnt[k]) begin
            n_bad++; $display("FAIL stall_cnt edge %0d: got %0d want %0d", k + 1, CNT, ecnt[k]);
         end
         n_cmp++;
      end
   endtask

   task automatic test_alt_valid();
      logic [W-1:0] eq  [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      bit           evo [4] = '{1, 0, 1, 0};
      do_reset();
      EN = 1;
      for (int k = 0; k < 7; k++) begin
         D  = (k < 4) ? 8'hA0 + 8'(k) : 8'h00;
         VI = (k < 4) ? ((k % 2) == 0) : 1'b0;
         tick();
         if (CNT > 3'd2) begin
            n_bad++; $display("FAIL alt_cnt_max edge %0d: got %0d want <=2", k + 1, CNT);
         end
         n_cmp++;
         if (k >= 3) begin
            if (Q !== eq[k-3] || VO !== evo[k-3]) begin
               n_bad++;
               $display("FAIL alt_q edge %0d: got %h/%b want %h/%b", k + 1, Q, VO, eq[k-3], evo[k-3]);
            end
            n_cmp++;
         end
      end
   endtask

   task automatic test_clr_stall();
      do_reset();
      EN = 1; VI = 1;
      for (int k = 0; k < 6; k++) begin
         D = 8'($urandom_range(1, 255));
         tick();
         if (int'(CNT) != ((k + 1 < 4) ? k + 1 : 4)) begin
            n_bad++; $display("FAIL full_cnt edge %0d: got %0d want %0d", k + 1, CNT, (k + 1 < 4) ? k + 1 : 4);
         end
         n_cmp++;
      end
      EN = 0; CLR = 1;
      tick();
      CLR = 0;
      if (Q !== 8'h00 || VO !== 1'b0 || CNT !== 3'd0) begin
         n_bad++; $display("FAIL clr_stall: got q=%h vo=%b cnt=%0d want q=00 vo=0 cnt=0", Q, VO, CNT);
      end
      n_cmp++;
   endtask

   task automatic test_async_reset();
      do_reset();
      EN = 1; VI = 1;
      for (int k = 0; k < 4; k++) begin
         D = 8'hC0 + 8'(k);
         tick();
      end
      if (CNT !== 3'd4 || Q !== 8'hC0) begin
         n_bad++; $display("FAIL ares_fill: got q=%h cnt=%0d want q=c0 cnt=4", Q, CNT);
      end
      n_cmp++;
      #2 RST_N = 1'b0;
      model_reset();
      #1;
      if (Q !== 8'h00 || VO !== 1'b0 || CNT !== 3'd0) begin
         n_bad++; $display("FAIL ares_now: got q=%h vo=%b cnt=%0d want q=00 vo=0 cnt=0", Q, VO, CNT);
      end
      n_cmp++;
      tick();
      #2 RST_N = 1'b1;
      D = 8'h5A; VI = 1; EN = 1;
      tick();
      if (CNT !== 3'd1 || Q !== 8'h00 || VO !== 1'b0) begin
         n_bad++; $display("FAIL ares_release: got q=%h vo=%b cnt=%0d want q=00 vo=0 cnt=1", Q, VO, CNT);
      end
      n_cmp++;
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         EN  = ($urandom_range(0, 3) != 0);
         CLR = ($urandom_range(0, 19) == 0);
         VI  = $urandom_range(0, 1);
         D   = 8'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            #2 RST_N = 1'b0;
            model_reset();
            #1;
            if (Q !== 8'h00 || CNT !== 3'd0) begin
               n_bad++; $display("FAIL rand_ares %0d: got q=%h cnt=%0d want q=00 cnt=0", k, Q, CNT);
            end
            n_cmp++;
            RST_N = 1'b1;
         end
         tick();
         if (Q !== md[DP-1] || VO !== mv[DP-1] || int'(CNT) != model_cnt()) begin
            n_bad++;
            $display("FAIL rand %0d: got q=%h vo=%b cnt=%0d want q=%h vo=%b cnt=%0d",
                     k, Q, VO, CNT, md[DP-1], mv[DP-1], model_cnt());
         end
         n_cmp++;
      end
      EN = 0; CLR = 0;
   endtask

   task automatic test_depth1();
      en1 = 1; vi1 = 1; d1 = 8'h3C;
      tick();
      if (q1 !== 8'h3C || vo1 !== 1'b1 || cnt1 !== 1'b1) begin
         n_bad++; $display("FAIL d1_load: got q=%h vo=%b cnt=%b want q=3c vo=1 cnt=1", q1, vo1, cnt1);
      end
      n_cmp++;
      en1 = 0; d1 = 8'hFF; vi1 = 0;
      tick();
      if (q1 !== 8'h3C || vo1 !== 1'b1) begin
         n_bad++; $display("FAIL d1_hold: got q=%h vo=%b want q=3c vo=1", q1, vo1);
      end
      n_cmp++;
      en1 = 1; vi1 = 0; d1 = 8'h81;
      tick();
      if (q1 !== 8'h81 || vo1 !== 1'b0 || cnt1 !== 1'b0) begin
         n_bad++; $display("FAIL d1_novalid: got q=%h vo=%b cnt=%b want q=81 vo=0 cnt=0", q1, vo1, cnt1);
      end
      n_cmp++;
      en1 = 0; clr1 = 1; vi1 = 1;
      tick();
      clr1 = 0;
      if (q1 !== 8'h00 || vo1 !== 1'b0) begin
         n_bad++; $display("FAIL d1_clr: got q=%h vo=%b want q=00 vo=0", q1, vo1);
      end
      n_cmp++;
   endtask

   initial begin
      model_reset();
      #3;
      test_reset();
      test_stream();
      test_stall();
      test_alt_valid();
      test_clr_stall();
      test_async_reset();
      test_random();
      test_depth1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data bits per stage (>=1).
REQ-002 Parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 Parameter INIT, default 0, WIDTH-bit data value loaded on reset and on clear.
REQ-004 CK  input  1  single clock; all state SHALL update on rising edge only.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 EN  input  1  advance enable; 0 = stall, all stages hold.
REQ-007 CLR  input  1  synchronous flush of all stages.
REQ-008 VI  input  1  input valid qualifier for D.
REQ-009 D  input  WIDTH  input data.
REQ-010 Q  output  WIDTH  data of final stage (stage DEPTH-1).
REQ-011 VO  output  1  valid bit of final stage.
REQ-012 CNT  output  $clog2(DEPTH+1)  number of stages currently holding valid data.

Function
REQ-013 State: DEPTH data registers S[0..DEPTH-1] (WIDTH bits each) and DEPTH valid bits V[0..DEPTH-1].
REQ-014 Rising CK, CLR=1: all S <= INIT, all V <= 0, regardless of EN, VI, D.
REQ-015 Rising CK, CLR=0, EN=1: S[0] <= D, V[0] <= VI; for i>=1, S[i] <= S[i-1], V[i] <= V[i-1].
REQ-016 Rising CK, CLR=0, EN=0: all S and V hold; D and VI ignored.
REQ-017 D SHALL be captured into S[0] on every advance, whether VI is 0 or 1 (plain DFF semantics); only V tracks validity.
REQ-018 Q = S[DEPTH-1], VO = V[DEPTH-1], both direct register outputs, no combinational path from any input.
REQ-019 CNT = population count of V, combinational from V only; range 0..DEPTH, never wraps.
REQ-020 Latency: with EN=1 continuously, a value on D at edge k appears on Q after edge k+DEPTH-1 (i.e. DEPTH edges including the capture edge).
REQ-021 Stalls add exactly one cycle of latency per EN=0 edge; no data or valid bit is lost or duplicated across a stall.
REQ-022 CLR while EN=0 SHALL still flush; CLR has priority over EN.
REQ-023 Full pipeline (CNT=DEPTH) with EN=1, VI=1 SHALL keep CNT=DEPTH; oldest entry leaves via Q as new enters; no overflow state exists.
REQ-024 DEPTH=1: block SHALL behave as a single enabled DFF with valid; CNT width 1.

Reset
REQ-025 RST_N=0 SHALL immediately (without CK edge) force all S to INIT and all V to 0; hence Q=INIT, VO=0, CNT=0.
REQ-026 While RST_N=0, CK edges SHALL have no effect; first update occurs on the first rising CK after RST_N rises.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight data; no partial stage update.

Verification (WIDTH=8, DEPTH=4, INIT=0)
REQ-028 Reset then EN=1, VI=1, D=0x11,0x22,0x33,0x44,0x55 on successive edges -> Q=0x11 VO=1 after 4th edge, 0x22 after 5th; CNT 1,2,3,4,4.
REQ-029 Same stream with EN=0 for 2 edges after 0x22 enters -> Q=0x11 delayed exactly 2 cycles, sequence intact, CNT held at 2 during stall.
REQ-030 Alternate VI=1/0 with D=0xA0..0xA3 -> Q shows 0xA0..0xA3 in order, VO=1,0,1,0; CNT never exceeds 2.
REQ-031 Pipeline full (CNT=4), assert CLR with EN=0 -> next edge Q=0x00, VO=0, CNT=0.
REQ-032 Pipeline full, drop RST_N between CK edges -> Q=0x00, VO=0, CNT=0 immediately; release, one edge with D=0x5A VI=1 -> CNT=1, Q still 0x00.
REQ-033 DEPTH=1 build: D=0x3C VI=1 EN=1 -> Q=0x3C VO=1 after one edge; EN=0, D=0xFF -> Q holds 0x3C.
